// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: AES-128 key-schedule sequencer feeding an 11-entry round-key file.
// Define KEYSCHED_RD_REG_EN to register the read port (1-cycle latency); default is combinational.
module key_schedule_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] keyin,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data,
    output logic         rd_valid
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d, wr_cnt_q, wr_cnt_d;
    logic         done_q, done_d;
    logic         accept;
    logic [127:0] cur_key_q, next_key;
    logic [127:0] rk_q [0:10];
    logic [31:0]  w3, temp, n0, n1, n2, n3;
    logic         rd_hit;
    logic [127:0] rd_word;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (a^254) plus the affine transform, avoiding a 256-entry table
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w3       = cur_key_q[31:0];
    assign temp     = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                      ^ {rcon(rnd_q), 24'h0};
    assign n0       = cur_key_q[127:96] ^ temp;
    assign n1       = cur_key_q[95:64] ^ n0;
    assign n2       = cur_key_q[63:32] ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};
    assign accept   = start && state_q != EXPAND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rnd_q    <= 4'd0;
            wr_cnt_q <= 4'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            wr_cnt_q <= wr_cnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rnd_d    = rnd_q;
        wr_cnt_d = wr_cnt_q;
        done_d   = 1'b0;
        if (accept) begin
            state_d  = EXPAND;
            rnd_d    = 4'd0;
            wr_cnt_d = 4'd1;
        end else if (state_q == EXPAND) begin
            state_d  = rnd_q == 4'd9 ? READY : EXPAND;
            rnd_d    = rnd_q + 4'd1;
            wr_cnt_d = wr_cnt_q == 4'd11 ? 4'd11 : wr_cnt_q + 4'd1;
            done_d   = rnd_q == 4'd9;
        end
    end

    always_comb begin
        busy      = state_q == EXPAND;
        key_ready = state_q == READY;
        done      = done_q;
    end

    // Storage has no reset: wr_cnt gates every read
    always_ff @(posedge clk) begin
        if (accept) begin
            rk_q[0]   <= keyin;
            cur_key_q <= keyin;
        end else if (state_q == EXPAND) begin
            rk_q[rnd_q + 4'd1] <= next_key;
            cur_key_q          <= next_key;
        end
    end

    assign rd_hit  = rd_addr < wr_cnt_q && rd_addr <= 4'd10;
    assign rd_word = rd_hit ? rk_q[rd_addr] : '0;

`ifdef KEYSCHED_RD_REG_EN
    logic         rd_valid_q;
    logic [127:0] rd_data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_hit;
            rd_data_q  <= rd_word;
        end
    end
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    assign rd_valid = rd_hit;
    assign rd_data  = rd_word;
`endif
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: scoreboard bench for key_schedule_ctrl using FIPS-197 and all-zero key vectors.
module tb_key_schedule_ctrl;
    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [127:0] keyin = '0;
    logic [3:0]   rd_addr = '0;
    logic         busy, done, key_ready, rd_valid;
    logic [127:0] rd_data;

`ifdef KEYSCHED_RD_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ALT  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK5    = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {string tag; logic [3:0] addr; logic [127:0] data;} exp_t;
    exp_t sb[$];
    int n_checks = 0, n_fail = 0;

    key_schedule_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .keyin(keyin),
        .busy(busy), .done(done), .key_ready(key_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [3:0] a, input logic [127:0] d);
        sb.push_back('{tag, a, d});
    endtask

    task automatic drain;
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_addr = e.addr;
            if (LAT != 0) tick;
            else #1;
            check({e.tag, "_valid"}, {127'd0, rd_valid}, 128'd1);
            check(e.tag, rd_data, e.data);
        end
    endtask

    task automatic fire(input logic [127:0] k);
        keyin = k;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        int k, first_v, drop, back;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_key_ready", {127'd0, key_ready}, 128'd0);
        check("rst_rd_valid", {127'd0, rd_valid}, 128'd0);
        check("rst_rd_data", rd_data, 128'd0);

        rd_addr = 4'd5;
        push("fips_rk0", 4'd0, K_FIPS);
        push("fips_rk1", 4'd1, RK1);
        push("fips_rk5", 4'd5, RK5);
        push("fips_rk10", 4'd10, RK10);
        fire(K_FIPS);
        check("busy_e0", {127'd0, busy}, 128'd1);
        check("rd5_e0", {127'd0, rd_valid}, 128'd0);
        k = 0;
        first_v = -1;
        while (!done && k < 30) begin
            tick;
            k++;
            if (rd_valid && first_v < 0) begin
                first_v = k;
                check("rd5_early_data", rd_data, RK5);
            end
        end
        check("latency", k, 10);
        check("rd5_first_edge", first_v, 5 + LAT);
        check("busy_at_done", {127'd0, busy}, 128'd0);
        check("key_ready_at_done", {127'd0, key_ready}, 128'd1);
        tick;
        check("done_one_cycle", {127'd0, done}, 128'd0);
        drain;

        push("ign_rk0", 4'd0, K_FIPS);
        push("ign_rk10", 4'd10, RK10);
        fire(K_FIPS);
        k = 0;
        while (!done && k < 30) begin
            tick;
            k++;
            if (k == 4) begin
                keyin = K_ALT;
                start = 1'b1;
                tick;
                k++;
                start = 1'b0;
            end
        end
        check("latency_ignored_start", k, 10);
        drain;

        rd_addr = 4'd3;
        fire(K_FIPS);
        repeat (6) tick;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {127'd0, busy}, 128'd0);
        check("abort_key_ready", {127'd0, key_ready}, 128'd0);
        check("abort_rd_valid", {127'd0, rd_valid}, 128'd0);
        tick;
        rst_n = 1'b1;
        tick;
        push("zero_rk10", 4'd10, RK10_Z);
        fire('0);
        k = 0;
        while (!done && k < 30) begin
            tick;
            k++;
        end
        check("latency_zero", k, 10);
        drain;

        rd_addr = 4'd3;
        if (LAT != 0) tick;
        else #1;
        check("rd3_before_restart", {127'd0, rd_valid}, 128'd1);
        keyin = K_FIPS;
        start = 1'b1;
        tick;
        k = 0;
        drop = rd_valid ? -1 : 0;
        back = -1;
        while (!done && k < 30) begin
            tick;
            k++;
            if (!rd_valid && drop < 0) drop = k;
            if (rd_valid && drop >= 0 && back < 0) back = k;
        end
        check("b2b_latency", k, 10);
        check("rd3_drop_edge", drop, LAT);
        check("rd3_back_edge", back, 3 + LAT);
        push("b2b_rk1", 4'd1, RK1);
        push("b2b_rk10", 4'd10, RK10);
        tick;
        check("b2b_restart_busy", {127'd0, busy}, 128'd1);
        check("b2b_restart_key_ready", {127'd0, key_ready}, 128'd0);
        start = 1'b0;
        k = 0;
        while (!done && k < 30) begin
            tick;
            k++;
        end
        check("b2b_latency2", k, 10);
        drain;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Sequencer for the AES-128 key schedule. It accepts a 128-bit cipher key and drives one combinational key-expansion stage (one round key per invocation) for ten consecutive cycles. It stores all eleven round keys (round 0 = cipher key) in a register file and serves them to the round datapath through an addressed read port. It sits between the key-load interface and the encryption round controller.

## Interface
- No parameters; Nr = 10, Nk = 4 fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE or READY
- keyin  in  128  cipher key, sampled on the start edge; bits [127:96] are w0
- busy  out  1  high while expansion is in progress
- done  out  1  one-cycle pulse when round key 10 has been written
- key_ready  out  1  all 11 round keys valid; held until next start or reset
- rd_addr  in  4  round-key index 0..10
- rd_data  out  128  round key at rd_addr
- rd_valid  out  1  the addressed entry is written for the current key

## Operation
- Internal expansion stage:
  - input: current key register plus 4-bit round index r;
  - rcon[31:24] = 01,02,04,08,10,20,40,80,1b,36 for r = 0..9; 00 otherwise;
  - output: next round key.
- FSM states:
  - IDLE: reset state.
  - EXPAND: round counter rnd = 0..9.
  - READY.
- IDLE/READY + start:
  - latch keyin into cur_key and rk[0];
  - rnd <= 0; clear key_ready;
  - go to EXPAND.
- EXPAND, each cycle:
  - rk[rnd+1] <= expand(cur_key, rnd); cur_key <= same value; rnd <= rnd+1.
  - When rnd == 9: pulse done, set key_ready, go to READY.
- start during EXPAND is ignored; the current expansion continues unchanged.
- Written-entry count wr_cnt (0..11) tracks valid entries.
  - rd_valid = (rd_addr < wr_cnt) && rd_addr <= 10.
  - rd_addr 11..15: rd_data = 0, rd_valid = 0.
- On a new start, old entries stay readable in storage but rd_valid deasserts for them: wr_cnt resets to 1 on the start edge.
- Round counter widths:
  - rnd is 4 bits and never exceeds 9 in EXPAND.
  - wr_cnt is 4 bits and saturates at 11.

## Timing
- Reset values (async assert, sync release):
  - state = IDLE, rnd = 0, wr_cnt = 0;
  - busy = 0, done = 0, key_ready = 0, rd_valid = 0, rd_data = 0;
  - register file contents are don't-care; rd_valid gates them.
- Start sampled at edge E0:
  - rk[0] valid after E0; busy = 1 from E0.
  - rk[n] valid after edge E0+n.
  - done = 1 and key_ready = 1 after edge E0+10; busy = 0 at the same time.
  - Total latency: 10 cycles from the start edge to done.
- The next start is accepted at E0+10 or later, including the cycle done is high.
- Reset asserted mid-EXPAND: immediate return to IDLE; the expansion is aborted; key_ready = 0.
- Read port latency is set by the configuration macro below.

## Configuration
- KEYSCHED_RD_REG_EN
  - Defined: rd_data and rd_valid are registered, with 1-cycle latency from rd_addr. A key written at edge N is readable at edge N+1 and visible one cycle after that.
  - Undefined: rd_data and rd_valid are combinational from rd_addr and storage. An entry is visible in the same cycle it is written, i.e. after the writing edge.

## Test plan
- Reset, then no start: all outputs 0; rd_addr = 0 gives rd_valid = 0.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - done pulses exactly 10 cycles after start;
  - rk[1] = a0fafe1788542cb123a339392a6c7605;
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Second start during EXPAND (after 4 cycles, with a different keyin): ignored; the first key's rk[10] is still correct at cycle 10.
- Read while expanding: rd_addr = 5 gives rd_valid = 0 until edge E0+5, then the correct value. Check with the macro both on and off.
- rst_n pulsed low at cycle 6 of EXPAND: busy = 0 and key_ready = 0 immediately. A restart with an all-zero key gives rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-to-back starts with start held high in READY: a new expansion begins on the edge after the previous done. rd_valid for rd_addr = 3 drops at the new start edge and returns at E0+3.
